// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the memory stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait states, byte-lane stores, held response.
// Optional out-of-range error reporting is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      stateR, nextStateS;
  logic [3:0]  cntR, nextCntS;
  logic        weR;
  logic [31:0] addrR;
  logic [31:0] wdataR;
  logic [3:0]  beR;
  logic [31:0] rdataR, nextRdataS;
  logic        errR, nextErrS;
  logic        readyR, validR, busyR;

  logic        acceptS, commitS, writeEnS, rangeErrS;
  logic        opWeS;
  logic [31:0] opAddrS;
  logic [31:0] opWdataS;
  logic [3:0]  opBeS;
  logic [AW-1:0] idxS;
  logic        unusedAddrS;

  logic [31:0] mem [DEPTH_WORDS];

  assign acceptS = (stateR == IDLE) && readyR && bus.req_valid;

  // With zero wait states the commit edge is also the accept edge, so the live request is used.
  assign opWeS    = (stateR == IDLE) ? bus.req_we    : weR;
  assign opAddrS  = (stateR == IDLE) ? bus.req_addr  : addrR;
  assign opWdataS = (stateR == IDLE) ? bus.req_wdata : wdataR;
  assign opBeS    = (stateR == IDLE) ? bus.req_be    : beR;
  assign idxS     = opAddrS[AW+1:2];
  assign unusedAddrS = ^{opAddrS[31:AW+2], opAddrS[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  assign rangeErrS = (64'(opAddrS) >= (64'(DEPTH_WORDS) * 64'd4));
`else
  assign rangeErrS = 1'b0;
`endif

  assign writeEnS = commitS && opWeS && !rangeErrS && rst;

  // Next-state, wait counter and response data selection.
  always_comb begin
    nextStateS = stateR;
    nextCntS   = cntR;
    nextRdataS = rdataR;
    nextErrS   = errR;
    commitS    = 1'b0;
    case (stateR)
      IDLE: begin
        if (acceptS && (WAIT_CYCLES > 0)) begin
          nextStateS = WAIT;
          nextCntS   = WAIT_LOAD;
        end else if (acceptS) begin
          nextStateS = RESP;
          commitS    = 1'b1;
        end else begin
          nextStateS = IDLE;
        end
      end
      // Counter starts at WAIT_CYCLES so RESP lands WAIT_CYCLES+1 edges after accept.
      WAIT: begin
        if (cntR == 4'd0) begin
          nextStateS = RESP;
          commitS    = 1'b1;
        end else begin
          nextCntS   = cntR - 4'd1;
        end
      end
      RESP: begin
        if (validR && bus.rsp_ready) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = RESP;
        end
      end
      default: begin
        nextStateS = IDLE;
        nextCntS   = 4'd0;
      end
    endcase
    if (commitS) begin
      nextRdataS = (opWeS || rangeErrS) ? 32'd0 : mem[idxS];
      nextErrS   = rangeErrS;
    end else begin
      nextErrS   = errR;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR <= IDLE;
      cntR   <= 4'd0;
      rdataR <= 32'd0;
      errR   <= 1'b0;
      readyR <= 1'b1;
      validR <= 1'b0;
      busyR  <= 1'b0;
    end else begin
      stateR <= nextStateS;
      cntR   <= nextCntS;
      rdataR <= nextRdataS;
      errR   <= nextErrS;
      readyR <= (nextStateS == IDLE);
      validR <= (nextStateS == RESP);
      busyR  <= (nextStateS != IDLE);
    end
  end

  // Request capture on accept; later changes on req_* are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weR    <= 1'b0;
      addrR  <= 32'd0;
      wdataR <= 32'd0;
      beR    <= 4'd0;
    end else if (acceptS) begin
      weR    <= bus.req_we;
      addrR  <= bus.req_addr;
      wdataR <= bus.req_wdata;
      beR    <= bus.req_be;
    end
  end

  // Byte-lane RAM write on the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (writeEnS) begin
      for (int i = 0; i < 4; i++) begin
        if (opBeS[i]) begin
          mem[idxS][8*i +: 8] <= opWdataS[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = readyR;
  assign bus.rsp_valid = validR;
  assign bus.rsp_rdata = rdataR;
  assign bus.rsp_err   = errR;
  assign bus.busy      = busyR;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, reset/backpressure sequences, random traffic vs. a word model.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] modelMem[DEPTH];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // One full transaction; returns the response seen when rsp_valid first rises.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_we    = $urandom_range(0, 1);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom_range(0, 15));
    bus.req_valid = $urandom_range(0, 1);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(WAITC + 1));
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, rdata);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_hs_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b0;
  endtask

  // Reference model: word-level memory with byte merge and optional range error.
  task automatic modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] rdata, output logic err);
    int idx;
`ifdef DMEM_RANGE_CHECK_EN
    err = (64'(addr) >= 64'(DEPTH) * 64'd4);
`else
    err = 1'b0;
`endif
    idx   = int'((addr / 32'd4) % 32'(DEPTH));
    rdata = 32'd0;
    if (!err && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) modelMem[idx] = (modelMem[idx] & ~(32'hFF << (8 * b))) | (wdata & (32'hFF << (8 * b)));
      end
    end else if (!err) begin
      rdata = modelMem[idx];
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] expRd;
    logic        expEr;
    int          n;
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b1, 32'h10,   32'hABCD_EF01, 4'hF, 0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,         4'hA, 1, 32'hABCD_EF01, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   32'h1234_5678, 4'hF, 0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h20,   32'hFFFF_FFFF, 4'h5, 2, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,         4'h0, 0, 32'h12FF_56FF, 1'b0};
    vecs[5]  = '{1'b1, 32'h22,   32'h0,         4'h0, 0, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h20,   32'h0,         4'hF, 0, 32'h12FF_56FF, 1'b0};
    vecs[7]  = '{1'b1, 32'h30,   32'hCAFE_BABE, 4'hF, 0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0,    32'h1111_1111, 4'hF, 0, 32'h0, 1'b0};
`ifdef DMEM_RANGE_CHECK_EN
    vecs[9]  = '{1'b1, 32'h1000, 32'h2222_2222, 4'hF, 0, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 32'h0,    32'h0,         4'hF, 0, 32'h1111_1111, 1'b0};
    vecs[11] = '{1'b0, 32'h1010, 32'h0,         4'hF, 0, 32'h0, 1'b1};
`else
    vecs[9]  = '{1'b1, 32'h1000, 32'h2222_2222, 4'hF, 0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,    32'h0,         4'hF, 0, 32'h2222_2222, 1'b0};
    vecs[11] = '{1'b0, 32'h1010, 32'h0,         4'hF, 0, 32'hABCD_EF01, 1'b0};
`endif

    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_be    = 4'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_rdata",     bus.rsp_rdata,      32'd0);
    check("rst_err",       32'(bus.rsp_err),   32'd0);

    for (int i = 0; i < 12; i++) begin
      transact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].expErr));
    end

    // Long response backpressure on a load.
    transact(1'b0, 32'h20, 32'h0, 4'hF, 5, rd, er);
    check("bp_rdata", rd, 32'h12FF_56FF);

    // Reset pulsed during WAIT discards the pending store.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'h5555_AAAA;
    bus.req_be = 4'hF; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rdata", bus.rsp_rdata,      32'd0);
    @(negedge clk);
    rst = 1'b1;
    transact(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    check("mid_old_word", rd, 32'hCAFE_BABE);

    // Reset while a response is pending drops it immediately.
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_pending_rdata", bus.rsp_rdata, 32'hABCD_EF01);
    #2 rst = 1'b0;
    #1;
    check("resp_drop_valid", 32'(bus.rsp_valid), 32'd0);
    check("resp_drop_rdata", bus.rsp_rdata,      32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random phase: preload words 0..15, then random traffic against the model.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      modelMem[i] = v;
      transact(1'b1, 32'(i * 4), v, 4'hF, 0, rd, er);
      check("preload_err", 32'(er), 32'd0);
    end
    for (int k = 0; k < 80; k++) begin
      logic        we;
      logic [31:0] addr, wdata, upper;
      logic [3:0]  be;
      we    = $urandom_range(0, 1);
      upper = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 32'hF_FFFF)) : 32'd0;
      addr  = (upper << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      modelAccess(we, addr, wdata, be, expRd, expEr);
      transact(we, addr, wdata, be, $urandom_range(0, 3), rd, er);
      check($sformatf("rand%0d_rdata", k), rd, expRd);
      check($sformatf("rand%0d_err", k), 32'(er), 32'(expEr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
